// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction-memory front end with IF/ID output
// latch and a one-entry hold buffer for words returning under a downstream stall.
// Optional feature macro: IFU_HALT_DETECT_EN enables HALT detection and the
// HALTED state; without it HALT_OPCODE words are ordinary instructions and
// halt is tied low.
module instr_fetch_unit #(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] npc,
    output logic        halt
);

`ifdef IFU_HALT_DETECT_EN
    localparam bit HALT_DETECT = 1'b1;
`else
    localparam bit HALT_DETECT = 1'b0;
`endif

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;

    logic [31:0] pc_plus4;
    logic        load_is_halt;
    logic        buf_is_halt;

    assign pc_plus4     = pc_q + 32'd4;
    assign load_is_halt = HALT_DETECT && (imemload[31:26] == HALT_OPCODE);
    assign buf_is_halt  = HALT_DETECT && (buf_q[31:26] == HALT_OPCODE);

    // Next-state and datapath update; priority is HALTED, then redirect, then stall/ihit.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        halt_d  = halt_q;

        case (state_q)
            FETCH: begin
                if (pc_src) begin
                    // Any word returning in the redirect cycle is on the wrong path.
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                end else if (ihit && !stall) begin
                    instr_d = imemload;
                    npc_d   = pc_plus4;
                    valid_d = 1'b1;
                    if (load_is_halt) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end else if (ihit) begin
                    // Park the word; pc already points past it so the drain uses pc as npc.
                    buf_d   = imemload;
                    pc_d    = pc_plus4;
                    state_d = HOLD;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (pc_src) begin
                    pc_d    = branch_target;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (!stall) begin
                    instr_d = buf_q;
                    npc_d   = pc_q;
                    valid_d = 1'b1;
                    if (buf_is_halt) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and output registers, asynchronously cleared to the reset image.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            buf_q   <= '0;
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

    assign imemREN     = (state_q == FETCH);
    assign imemaddr    = {pc_q[31:2], 2'b00};
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign npc         = npc_q;
    assign halt        = HALT_DETECT ? halt_q : 1'b0;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end that supplies the control unit's `instr` input and consumes its `pc_src` redirect. It owns the PC, drives the instruction-memory read port (`imemREN`/`imemaddr`, `ihit`/`imemload`), and registers each fetched word into an IF/ID-style output latch. A one-entry hold buffer absorbs a word that returns while the downstream stage is stalled. HALT detection stops fetching.

## Interface
- `PC_INIT`, default 32'h0000_0000: PC value loaded at reset.
- `HALT_OPCODE`, default 6'b111111: opcode (`instr[31:26]`) treated as HALT.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `ihit`  in  1  instruction memory returns `imemload` this cycle.
- `imemload`  in  32 (`word_t`)  instruction word from memory.
- `imemREN`  out  1  instruction read enable.
- `imemaddr`  out  32  fetch address; equals `{pc[31:2],2'b00}`.
- `stall`  in  1  downstream cannot accept a new instruction.
- `pc_src`  in  1  redirect request from the control unit.
- `branch_target`  in  32  redirect address, used when `pc_src`=1.
- `instr`  out  32  registered instruction to the control unit.
- `instr_valid`  out  1  `instr` holds a live instruction.
- `npc`  out  32  address of `instr` + 4, for branch and link arithmetic.
- `halt`  out  1  sticky; HALT accepted.

## Operation
- Registers: `pc`, `state` ∈ {FETCH, HOLD, HALTED}, `buf` (32-bit), `instr`, `instr_valid`, `npc`, `halt`.
- `imemREN` = 1 only in FETCH. This is combinational from state, so it reads 1 during reset.
- Priority in every state: reset, then HALTED, then `pc_src`, then `stall`/`ihit`.
- **FETCH**
  - `pc_src`: `pc`←`branch_target`; `instr_valid`←0; any same-cycle `ihit` word is discarded; stay in FETCH.
  - `ihit` & !`stall`:
    - `instr`←`imemload`, `npc`←`pc`+4, `instr_valid`←1.
    - If the opcode equals HALT_OPCODE: go to HALTED, set `halt`←1, leave `pc` unchanged.
    - Otherwise: `pc`←`pc`+4.
  - `ihit` & `stall`: `buf`←`imemload`, `pc`←`pc`+4, go to HOLD. `instr`, `instr_valid`, and `npc` are unchanged.
  - !`ihit` & !`stall`: `instr_valid`←0 (bubble).
  - !`ihit` & `stall`: all outputs hold.
- **HOLD** (`imemREN`=0)
  - `pc_src`: drop `buf`, `pc`←`branch_target`, `instr_valid`←0, go to FETCH.
  - !`stall`: `instr`←`buf`, `npc`←`pc`, `instr_valid`←1.
    - If `buf` is HALT: go to HALTED, set `halt`←1.
    - Otherwise: go to FETCH.
  - `stall`: hold.
- **HALTED** (`imemREN`=0)
  - `pc_src` and `ihit` are ignored.
  - `instr_valid`←0 on the first cycle with !`stall`.
  - `halt` stays 1 until reset.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. `branch_target[1:0]` is stored but masked on `imemaddr`.

## Timing
- Reset values (async): `pc`=PC_INIT, `state`=FETCH, `buf`=0, `instr`=0, `instr_valid`=0, `npc`=0, `halt`=0; `imemREN`=1 and `imemaddr`=PC_INIT.
- Fetch latency: the word on `imemload` in the `ihit` cycle appears on `instr` the next cycle.
- Redirect: with `pc_src` high in cycle N, `imemaddr`=`branch_target` in cycle N+1 and `instr_valid`=0 in N+1.
- The HOLD drain takes 1 cycle after `stall` falls.
- Back-to-back throughput: one instruction per cycle while `ihit`=1 and `stall`=0.
- Reset mid-operation: buffered or pending words are lost; fetch restarts at PC_INIT on the first edge after `nRST` rises.

## Configuration
- `IFU_HALT_DETECT_EN` defined: HALT detection and the HALTED state behave as above.
- Not defined:
  - HALT_OPCODE words are fetched as ordinary instructions and `pc` keeps advancing.
  - HALTED is unreachable and `halt` is tied to 0.

## Test plan
- Reset release with PC_INIT=0 and `ihit`=1 every cycle, memory returns addr+1: `imemaddr` sequence 0,4,8,C; `instr` sequence 1,5,9,D, each one cycle later; `npc`=4,8,C,10.
- `ihit` with `stall`=1 at pc=8: HOLD entered, `imemREN`=0, `instr` unchanged. Drop `stall`: `instr`=buf, `npc`=C, then `imemaddr`=C.
- `pc_src`=1 with `branch_target`=32'h40 in the same cycle as `ihit`: the returned word is discarded, `instr_valid`=0, next `imemaddr`=32'h40.
- `pc_src` during HOLD: the buffer is dropped, `imemaddr`=`branch_target`, and the buffered word never appears on `instr`.
- Fetch 32'hFFFF_FFFF at pc=C (macro on): `instr_valid`=1 and `halt`=1 next cycle; `imemREN`=0 thereafter; `pc_src` is ignored. With the macro off, fetch continues at 10.
- PC_INIT=32'hFFFF_FFFC: the second fetch address is 0. Assert `nRST` mid-HOLD: outputs return to reset values immediately.
